matrix_result_serializer: RTL and testbench
===========================================

MATRIX_RESULT_SERIALIZER -- requirements
Module: matrix_result_serializer

Interface
REQ-001 SHALL have parameter NOF_ROWS, default NOF_ROWS_MATRIX_C (8), meaning result matrix rows.
REQ-002 SHALL have parameter NOF_COLS, default NOF_COLS_MATRIX_C (8), meaning result matrix columns.
REQ-003 SHALL have parameter DATA_WIDTH, default OUTPUT_DATA_WIDTH (32), meaning result element width.
REQ-004 SHALL use one clock and a synchronous, active-high reset (ports clk, rst).
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- res_valid  in  1  result matrix presented.
- res_data  in  NOF_ROWS*NOF_COLS*DATA_WIDTH  flattened matrix; element (r,c) at slice index r*NOF_COLS+c.
- res_ready  out  1  serializer can capture.
- m_valid  out  1  output element valid.
- m_data  out  DATA_WIDTH  output element.
- m_index  out  ELEM_IDX_WIDTH  row-major index of m_data.
- m_ready  in  1  downstream accepts.
- m_last  out  1  final element of matrix.
- busy  out  1  streaming in progress.
- drop_err  out  1  sticky: matrix offered while busy.

Function
REQ-006 SHALL implement FSM states IDLE and STREAM.
REQ-007 SHALL drive res_ready=1 exactly when state is IDLE (decoded from state register only).
REQ-008 In IDLE with res_valid=1, SHALL register all of res_data into an internal buffer, clear index to 0, and enter STREAM on the same edge.
REQ-009 SHALL assert m_valid and busy in the first cycle after capture (capture-to-valid latency 1 cycle); m_valid=0 in IDLE.
REQ-010 In STREAM, SHALL drive m_data=buffer[index] and m_index=index.
REQ-011 On m_valid&&m_ready with index<N-1 (N=NOF_ROWS*NOF_COLS), SHALL increment index; throughput 1 element/cycle with m_ready held high.
REQ-012 While m_valid=1 and m_ready=0, SHALL hold m_data, m_index and m_last stable.
REQ-013 SHALL assert m_last exactly when m_valid=1 and index==N-1.
REQ-014 On handshake with index==N-1, SHALL return to IDLE; m_valid=0 next cycle; earliest next capture is that IDLE cycle (one idle cycle between matrices).
REQ-015 res_valid in STREAM SHALL not alter buffer, index or the stream, and SHALL set drop_err to 1 until reset.
REQ-016 Buffer contents SHALL be unchanged outside capture cycles.

Reset
REQ-017 On rst=1 at a clock edge, SHALL enter IDLE, clear index, m_valid, m_last, busy and drop_err to 0, and drive res_ready=1 after the edge.
REQ-018 rst during STREAM SHALL abort the matrix; remaining elements are discarded; buffer need not be cleared.
REQ-019 rst SHALL take priority over a simultaneous res_valid or handshake.

Configuration
REQ-020 With MATRIX_SERIALIZER_ROW_LAST_EN defined, SHALL add output m_row_last (1 bit), asserted when m_valid=1 and index mod NOF_COLS == NOF_COLS-1; reset value 0.
REQ-021 Without MATRIX_SERIALIZER_ROW_LAST_EN, port m_row_last and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-022 The matrix package SHALL gain ELEM_IDX_WIDTH = $clog2(SIZE_OF_OUTPUT_MATRIX), typedef result_elem_t (DATA_WIDTH-bit logic), and enum serializer_state_t {IDLE, STREAM}.
REQ-023 SHALL be a single module with no sub-modules; the buffer is a register array of result_elem_t.

Verification
REQ-024 Capture res_data with element k = k+1 and m_ready constantly 1 -> 64 consecutive beats 1..64, m_index 0..63, m_last only on beat 63, m_valid first seen 1 cycle after capture.
REQ-025 Toggle m_ready 1,0,0,1 repeatedly -> no lost or duplicated element; m_data/m_index stable during stalls.
REQ-026 res_valid pulsed at element 10 with different data -> stream continues unchanged, drop_err=1 and remains 1 until rst.
REQ-027 rst asserted at element 20 -> next cycle m_valid=0, res_ready=1, drop_err=0; new matrix then streams from index 0.
REQ-028 Two matrices offered back-to-back (res_valid held high) -> second captured in the IDLE cycle after first m_last handshake; streams 0..63 intact.
REQ-029 With MATRIX_SERIALIZER_ROW_LAST_EN defined -> m_row_last high at indices 7,15,...,63 only; without it the build has no m_row_last port.

Source files
------------

// File: rtl/matrix_result_serializer_pkg.sv
// ============================================================================
//  Module   : matrix_result_serializer_pkg
//  Purpose  : Shared sizes, element type and serializer state encoding for
//             the result-matrix serializer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_result_serializer_pkg;

    // Result matrix geometry and element width
    localparam int NOF_ROWS_MATRIX_C     = 8;
    localparam int NOF_COLS_MATRIX_C     = 8;
    localparam int OUTPUT_DATA_WIDTH     = 32;
    localparam int SIZE_OF_OUTPUT_MATRIX = NOF_ROWS_MATRIX_C * NOF_COLS_MATRIX_C;

    // Width of a row-major element index into the result matrix
    localparam int ELEM_IDX_WIDTH = $clog2(SIZE_OF_OUTPUT_MATRIX);

    // One element of the result matrix
    typedef logic [OUTPUT_DATA_WIDTH-1:0] result_elem_t;

    // Serializer control states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } serializer_state_t;

endpackage : matrix_result_serializer_pkg

`default_nettype wire

// File: rtl/matrix_result_serializer.sv
// ============================================================================
//  Module   : matrix_result_serializer
//  Purpose  : Captures a complete flattened result matrix in one cycle and
//             streams its elements out in row-major order over a
//             valid/ready interface, one element per cycle.
//  Options  : MATRIX_SERIALIZER_ROW_LAST_EN - adds output m_row_last, high on
//             the last element of every matrix row.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_result_serializer
    import matrix_result_serializer_pkg::*;
#(
    parameter int NOF_ROWS   = NOF_ROWS_MATRIX_C,
    parameter int NOF_COLS   = NOF_COLS_MATRIX_C,
    parameter int DATA_WIDTH = OUTPUT_DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    // Matrix capture side
    input  logic                                   res_valid,
    input  logic [NOF_ROWS*NOF_COLS*DATA_WIDTH-1:0] res_data,
    output logic                                   res_ready,
    // Element stream side
    output logic                                   m_valid,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic [ELEM_IDX_WIDTH-1:0]              m_index,
    input  logic                                   m_ready,
    output logic                                   m_last,
`ifdef MATRIX_SERIALIZER_ROW_LAST_EN
    output logic                                   m_row_last,
`endif
    // Status
    output logic                                   busy,
    output logic                                   drop_err
);

    localparam int NOF_ELEMS = NOF_ROWS * NOF_COLS;
    localparam logic [ELEM_IDX_WIDTH-1:0] LAST_IDX = ELEM_IDX_WIDTH'(NOF_ELEMS - 1);

    serializer_state_t r_state;
    serializer_state_t w_next_state;

    result_elem_t              r_buffer [NOF_ELEMS];
    logic [ELEM_IDX_WIDTH-1:0] r_index;
    logic                      r_drop_err;

    logic w_capture;
    logic w_handshake;
    logic w_at_end;

    // Status decodes: everything visible downstream depends only on registers
    assign w_capture   = (r_state == IDLE) && res_valid;
    assign w_handshake = (r_state == STREAM) && m_ready;
    assign w_at_end    = (r_index == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: capture opens a stream, final handshake closes it
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (res_valid) begin
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                if (m_ready && w_at_end) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Matrix buffer: loaded only on capture, never reset (contents are
    // don't-care until the next capture overwrites them)
    always_ff @(posedge clk) begin
        if (!rst && w_capture) begin
            for (int k = 0; k < NOF_ELEMS; k++) begin
                r_buffer[k] <= result_elem_t'(res_data[k*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // Element index: restarts on capture, advances on each non-final handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
        end else if (w_capture) begin
            r_index <= '0;
        end else if (w_handshake && !w_at_end) begin
            r_index <= r_index + 1'b1;
        end
    end

    // Sticky overrun flag: a matrix offered while streaming is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_err <= 1'b0;
        end else if ((r_state == STREAM) && res_valid) begin
            r_drop_err <= 1'b1;
        end
    end

    // Output decode; index only moves on handshake so stalls hold everything
    assign res_ready = (r_state == IDLE);
    assign m_valid   = (r_state == STREAM);
    assign busy      = (r_state == STREAM);
    assign m_data    = DATA_WIDTH'(r_buffer[r_index]);
    assign m_index   = r_index;
    assign m_last    = m_valid && w_at_end;
    assign drop_err  = r_drop_err;

`ifdef MATRIX_SERIALIZER_ROW_LAST_EN
    // Row boundary marker: last column of the current row
    assign m_row_last = m_valid && ((int'(r_index) % NOF_COLS) == (NOF_COLS - 1));
`endif

endmodule : matrix_result_serializer

`default_nettype wire

// File: tb/tb_matrix_result_serializer.sv
// ============================================================================
//  Module   : tb_matrix_result_serializer
//  Purpose  : Directed self-checking bench for matrix_result_serializer.
//  Options  : MATRIX_SERIALIZER_ROW_LAST_EN - also checks m_row_last.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_result_serializer;
    import matrix_result_serializer_pkg::*;

    localparam int NR = 8;
    localparam int NC = 8;
    localparam int DW = 32;
    localparam int NE = NR * NC;

    logic                      clk;
    logic                      rst;
    logic                      res_valid;
    logic [NE*DW-1:0]          res_data;
    logic                      res_ready;
    logic                      m_valid;
    logic [DW-1:0]             m_data;
    logic [ELEM_IDX_WIDTH-1:0] m_index;
    logic                      m_ready;
    logic                      m_last;
    logic                      busy;
    logic                      drop_err;
`ifdef MATRIX_SERIALIZER_ROW_LAST_EN
    logic                      m_row_last;
`endif

    int checks = 0;
    int errors = 0;

    matrix_result_serializer #(
        .NOF_ROWS   (NR),
        .NOF_COLS   (NC),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_ready    (m_ready),
        .m_last     (m_last),
`ifdef MATRIX_SERIALIZER_ROW_LAST_EN
        .m_row_last (m_row_last),
`endif
        .busy       (busy),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element k of the matrix holds base + k + 1
    function automatic logic [NE*DW-1:0] make_matrix(input int base);
        logic [NE*DW-1:0] m;
        m = '0;
        for (int k = 0; k < NE; k++) begin
            m[k*DW +: DW] = DW'(base + k + 1);
        end
        return m;
    endfunction

    // Present a matrix for exactly one capture edge
    task automatic capture(input int base);
        res_data  = make_matrix(base);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        res_valid = 1'b0;
        res_data  = '0;
        m_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (res_ready !== 1'b1) begin
            errors++; $display("FAIL reset_res_ready: got %b expected 1", res_ready);
        end
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got valid=%b busy=%b last=%b expected 0/0/0", m_valid, busy, m_last);
        end
        checks++;
        if (drop_err !== 1'b0) begin
            errors++; $display("FAIL reset_drop_err: got %b expected 0", drop_err);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL idle_valid: got %b expected 0", m_valid);
        end
    endtask

    task automatic test_stream();
        m_ready = 1'b1;
        checks++;
        if (res_ready !== 1'b1) begin
            errors++; $display("FAIL stream_ready_before: got %b expected 1", res_ready);
        end
        capture(0);
        checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1 || res_ready !== 1'b0) begin
            errors++; $display("FAIL stream_latency: got valid=%b busy=%b ready=%b expected 1/1/0", m_valid, busy, res_ready);
        end
        for (int k = 0; k < NE; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== DW'(k + 1) || m_index !== ELEM_IDX_WIDTH'(k)
                || m_last !== (k == NE - 1)) begin
                errors++;
                $display("FAIL stream_beat %0d: got v=%b d=%0d i=%0d l=%b expected 1/%0d/%0d/%b",
                         k, m_valid, m_data, m_index, m_last, k + 1, k, (k == NE - 1));
            end
`ifdef MATRIX_SERIALIZER_ROW_LAST_EN
            checks++;
            if (m_row_last !== ((k % NC) == NC - 1)) begin
                errors++;
                $display("FAIL row_last %0d: got %b expected %b", k, m_row_last, ((k % NC) == NC - 1));
            end
`endif
            tick();
        end
        checks++;
        if (m_valid !== 1'b0 || res_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL stream_end: got valid=%b ready=%b busy=%b expected 0/1/0", m_valid, res_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int k;
        int c;
        pat = 4'b1001;
        m_ready = 1'b0;
        capture(100);
        k = 0;
        c = 0;
        while (k < NE && c < 400) begin
            m_ready = pat[c % 4];
            checks++;
            if (m_valid !== 1'b1 || m_data !== DW'(100 + k + 1) || m_index !== ELEM_IDX_WIDTH'(k)
                || m_last !== (k == NE - 1)) begin
                errors++;
                $display("FAIL bp_beat %0d cyc %0d: got v=%b d=%0d i=%0d l=%b expected 1/%0d/%0d/%b",
                         k, c, m_valid, m_data, m_index, m_last, 100 + k + 1, k, (k == NE - 1));
            end
            if (m_ready) k++;
            tick();
            c++;
        end
        checks++;
        if (k != NE) begin
            errors++; $display("FAIL bp_timeout: got %0d beats expected %0d", k, NE);
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL bp_end_valid: got %b expected 0", m_valid);
        end
        m_ready = 1'b1;
    endtask

    task automatic test_drop();
        m_ready = 1'b1;
        capture(200);
        for (int k = 0; k < NE; k++) begin
            res_valid = (k == 10);
            res_data  = (k == 10) ? make_matrix(900) : make_matrix(200);
            checks++;
            if (m_data !== DW'(200 + k + 1) || m_index !== ELEM_IDX_WIDTH'(k) || m_valid !== 1'b1) begin
                errors++;
                $display("FAIL drop_beat %0d: got v=%b d=%0d i=%0d expected 1/%0d/%0d",
                         k, m_valid, m_data, m_index, 200 + k + 1, k);
            end
            checks++;
            if (drop_err !== (k > 10)) begin
                errors++; $display("FAIL drop_flag %0d: got %b expected %b", k, drop_err, (k > 10));
            end
            tick();
        end
        res_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || drop_err !== 1'b1) begin
            errors++; $display("FAIL drop_end: got valid=%b drop=%b expected 0/1", m_valid, drop_err);
        end
        tick();
        tick();
        checks++;
        if (drop_err !== 1'b1) begin
            errors++; $display("FAIL drop_sticky: got %b expected 1", drop_err);
        end
    endtask

    task automatic test_rst_mid();
        m_ready = 1'b1;
        capture(300);
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (m_index !== ELEM_IDX_WIDTH'(20) || m_data !== DW'(321)) begin
            errors++; $display("FAIL rst_pre: got i=%0d d=%0d expected 20/321", m_index, m_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || res_ready !== 1'b1 || drop_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got valid=%b ready=%b drop=%b busy=%b expected 0/1/0/0",
                     m_valid, res_ready, drop_err, busy);
        end
        capture(400);
        for (int k = 0; k < NE; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== DW'(400 + k + 1) || m_index !== ELEM_IDX_WIDTH'(k)) begin
                errors++;
                $display("FAIL rst_restream %0d: got v=%b d=%0d i=%0d expected 1/%0d/%0d",
                         k, m_valid, m_data, m_index, 400 + k + 1, k);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        m_ready   = 1'b1;
        res_data  = make_matrix(500);
        res_valid = 1'b1;
        tick();
        res_data  = make_matrix(600);
        for (int k = 0; k < NE; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== DW'(500 + k + 1) || m_index !== ELEM_IDX_WIDTH'(k)) begin
                errors++;
                $display("FAIL b2b_first %0d: got v=%b d=%0d i=%0d expected 1/%0d/%0d",
                         k, m_valid, m_data, m_index, 500 + k + 1, k);
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b0 || res_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_gap: got valid=%b ready=%b expected 0/1", m_valid, res_ready);
        end
        tick();
        res_valid = 1'b0;
        for (int k = 0; k < NE; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== DW'(600 + k + 1) || m_index !== ELEM_IDX_WIDTH'(k)
                || m_last !== (k == NE - 1)) begin
                errors++;
                $display("FAIL b2b_second %0d: got v=%b d=%0d i=%0d l=%b expected 1/%0d/%0d/%b",
                         k, m_valid, m_data, m_index, m_last, 600 + k + 1, k, (k == NE - 1));
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got %b expected 0", m_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (drop_err !== 1'b0) begin
            errors++; $display("FAIL final_rst_drop: got %b expected 0", drop_err);
        end
    endtask

    initial begin
        rst       = 1'b1;
        res_valid = 1'b0;
        res_data  = '0;
        m_ready   = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_drop();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_matrix_result_serializer

`default_nettype wire
